d_pipe_reg: RTL and testbench

D_PIPE_REG -- requirements
Module: d_pipe_reg

---
 rtl/d_pipe_pkg.sv | 10 +
 rtl/d_pipe_reg_if.sv | 26 ++
 rtl/d_pipe_stage.sv | 24 ++
 rtl/d_pipe_reg.sv | 73 +++++++
 tb/tb_d_pipe_reg.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/d_pipe_pkg.sv
// Shared constants and sizing helper for the d_pipe_reg register pipeline.
package d_pipe_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  // Bits needed to hold an occupancy value in 0..depth.
  function automatic int cnt_w(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/d_pipe_reg_if.sv
// Handshake bus of d_pipe_reg: push side, pop side and occupancy.
interface d_pipe_reg_if #(
  parameter int WIDTH = d_pipe_pkg::DEF_WIDTH,
  parameter int DEPTH = d_pipe_pkg::DEF_DEPTH
);
  import d_pipe_pkg::*;

  logic                      En;
  logic [WIDTH-1:0]          D;
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          f;
  logic                      out_valid;
  logic                      out_ready;
  logic [cnt_w(DEPTH)-1:0]   count;

  modport master (
    output En, D, in_valid, out_ready,
    input  in_ready, f, out_valid, count
  );

  modport slave (
    input  En, D, in_valid, out_ready,
    output in_ready, f, out_valid, count
  );
endinterface

// File: rtl/d_pipe_stage.sv
// One pipeline slot: data register plus valid bit, loaded from upstream
// and emptied when it advances downstream.
module d_pipe_stage #(
  parameter int WIDTH = d_pipe_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [WIDTH-1:0] din,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      // A stage can drain and refill in the same cycle.
      valid <= load || (valid && !advance);
      if (load) data <= din;
    end
  end
endmodule

// File: rtl/d_pipe_reg.sv
// Bubble-collapsing register pipeline with valid/ready handshake on both ends,
// a global freeze enable and an occupancy counter.
module d_pipe_reg
  import d_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  d_pipe_reg_if.slave  bus
);
  localparam int CW = cnt_w(DEPTH);

  logic [DEPTH-1:0]            valid;
  logic [DEPTH-1:0]            adv;
  logic [DEPTH-1:0]            load;
  logic [DEPTH:0]              free;
  logic [DEPTH-1:0][WIDTH-1:0] data;
  logic [DEPTH-1:0][WIDTH-1:0] din;
  logic                        push;
  logic                        pop;
  logic [CW-1:0]               count;

  // Ready ripples from the sink back to stage 0, so a full pipe still
  // accepts a word when the sink pops in the same cycle.
  always_comb begin
    free        = '0;
    adv         = '0;
    free[DEPTH] = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv[i]  = bus.En && valid[i] && free[i+1];
      free[i] = !valid[i] || adv[i];
    end
  end

  assign push = bus.En && bus.in_valid && free[0];
  assign pop  = adv[DEPTH-1];

  always_comb begin
    load    = '0;
    din     = '0;
    load[0] = push;
    din[0]  = bus.D;
    for (int i = 1; i < DEPTH; i++) begin
      load[i] = adv[i-1];
      din[i]  = data[i-1];
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    d_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .load    (load[i]),
      .advance (adv[i]),
      .din     (din[i]),
      .valid   (valid[i]),
      .data    (data[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst)                count <= '0;
    else if (push && !pop)  count <= count + CW'(1);
    else if (pop && !push)  count <= count - CW'(1);
  end

  assign bus.in_ready  = bus.En && free[0];
  assign bus.out_valid = bus.En && valid[DEPTH-1];
  assign bus.f         = data[DEPTH-1];
  assign bus.count     = count;
endmodule

// File: tb/tb_d_pipe_reg.sv
// Directed bench for d_pipe_reg (WIDTH=8, DEPTH=4) plus a DEPTH=1 instance.
module tb_d_pipe_reg;
  import d_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  d_pipe_reg_if #(.WIDTH(8), .DEPTH(4)) bus ();
  d_pipe_reg_if #(.WIDTH(8), .DEPTH(1)) bus1 ();

  d_pipe_reg #(.WIDTH(8), .DEPTH(4)) dut  (.clk(clk), .rst(rst), .bus(bus));
  d_pipe_reg #(.WIDTH(8), .DEPTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic test_reset;
    repeat (2) tick();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (bus.f !== 8'h00) begin errors++; $display("FAIL reset_f got=%h exp=00", bus.f); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    settle();
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL release_out_valid got=%b exp=0", bus.out_valid); end
    tick();
  endtask

  task automatic test_stream;
    logic [7:0] e;
    logic       ev;
    bus.out_ready = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      bus.in_valid = (k < 4);
      bus.D = 8'h11 + 8'(k);
      settle();
      ev = (k >= 4 && k < 8);
      if (k < 4) begin
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready k=%0d got=%b exp=1", k, bus.in_ready); end
      end
      checks++; if (bus.out_valid !== ev) begin errors++; $display("FAIL stream_out_valid k=%0d got=%b exp=%b", k, bus.out_valid, ev); end
      if (ev) begin
        e = 8'h11 + 8'(k - 4);
        checks++; if (bus.f !== e) begin errors++; $display("FAIL stream_f k=%0d got=%h exp=%h", k, bus.f, e); end
      end
      if (k == 4) begin
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL stream_count4 got=%0d exp=4", bus.count); end
      end
      tick();
    end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL stream_count_end got=%0d exp=0", bus.count); end
  endtask

  task automatic test_backpressure;
    logic [7:0] e;
    bus.out_ready = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      bus.in_valid = 1'b1;
      bus.D = 8'h21 + 8'(k);
      settle();
      checks++; if (bus.in_ready !== (k < 4)) begin errors++; $display("FAIL bp_in_ready k=%0d got=%b exp=%b", k, bus.in_ready, (k < 4)); end
      if (k == 4) begin
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL bp_count got=%0d exp=4", bus.count); end
      end
      tick();
    end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) bus.in_valid = 1'b0;
      settle();
      if (j == 0) begin
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_chain_ready got=%b exp=1", bus.in_ready); end
      end
      e = 8'h21 + 8'(j);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid j=%0d got=%b exp=1", j, bus.out_valid); end
      checks++; if (bus.f !== e) begin errors++; $display("FAIL bp_f j=%0d got=%h exp=%h", j, bus.f, e); end
      tick();
    end
    settle();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got=%b exp=0", bus.out_valid); end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL bp_count_end got=%0d exp=0", bus.count); end
  endtask

  task automatic test_full_push_pop;
    logic [7:0] e;
    logic [2:0] ec;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.in_valid = 1'b1;
      bus.D = 8'h31 + 8'(k);
      tick();
    end
    bus.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      bus.D = 8'h35 + 8'(j);
      settle();
      e = 8'h31 + 8'(j);
      checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready j=%0d got=%b exp=1", j, bus.in_ready); end
      checks++; if (bus.f !== e) begin errors++; $display("FAIL full_f j=%0d got=%h exp=%h", j, bus.f, e); end
      checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL full_count j=%0d got=%0d exp=4", j, bus.count); end
      tick();
    end
    bus.in_valid = 1'b0;
    for (int j = 0; j < 4; j++) begin
      settle();
      e  = 8'h34 + 8'(j);
      ec = 3'(4 - j);
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL drain_out_valid j=%0d got=%b exp=1", j, bus.out_valid); end
      checks++; if (bus.f !== e) begin errors++; $display("FAIL drain_f j=%0d got=%h exp=%h", j, bus.f, e); end
      checks++; if (bus.count !== ec) begin errors++; $display("FAIL drain_count j=%0d got=%0d exp=%0d", j, bus.count, ec); end
      tick();
    end
    settle();
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL drain_count_end got=%0d exp=0", bus.count); end
  endtask

  task automatic test_freeze;
    logic [7:0] e;
    logic       ev;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.in_valid = 1'b1;
      bus.D = 8'h41 + 8'(k);
      tick();
    end
    bus.En = 1'b0;
    bus.D = 8'h4F;
    bus.out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      settle();
      checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL frz_in_ready j=%0d got=%b exp=0", j, bus.in_ready); end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL frz_out_valid j=%0d got=%b exp=0", j, bus.out_valid); end
      checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL frz_count j=%0d got=%0d exp=2", j, bus.count); end
      checks++; if (bus.f !== 8'h37) begin errors++; $display("FAIL frz_f_hold j=%0d got=%h exp=37", j, bus.f); end
      tick();
    end
    bus.En = 1'b1;
    bus.in_valid = 1'b0;
    for (int j = 0; j < 5; j++) begin
      settle();
      ev = (j == 2 || j == 3);
      checks++; if (bus.out_valid !== ev) begin errors++; $display("FAIL resume_out_valid j=%0d got=%b exp=%b", j, bus.out_valid, ev); end
      if (j >= 2) begin
        e = (j == 2) ? 8'h41 : 8'h42;
        checks++; if (bus.f !== e) begin errors++; $display("FAIL resume_f j=%0d got=%h exp=%h", j, bus.f, e); end
      end
      tick();
    end
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL resume_count got=%0d exp=0", bus.count); end
  endtask

  task automatic test_mid_reset;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.in_valid = 1'b1;
      bus.D = 8'h51 + 8'(k);
      tick();
    end
    rst = 1'b1;
    bus.D = 8'h5F;
    bus.out_ready = 1'b1;
    settle();
    checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL mrst_pre_count got=%0d exp=3", bus.count); end
    tick();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    settle();
    checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL mrst_count got=%0d exp=0", bus.count); end
    checks++; if (bus.f !== 8'h00) begin errors++; $display("FAIL mrst_f got=%h exp=00", bus.f); end
    for (int j = 0; j < 8; j++) begin
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mrst_ghost j=%0d got=%b exp=0 f=%h", j, bus.out_valid, bus.f); end
      tick();
    end
  endtask

  task automatic test_depth1;
    bus1.out_ready = 1'b0;
    bus1.in_valid = 1'b1;
    bus1.D = 8'h61;
    settle();
    checks++; if (bus1.in_ready !== 1'b1) begin errors++; $display("FAIL d1_in_ready0 got=%b exp=1", bus1.in_ready); end
    tick();
    bus1.D = 8'h62;
    settle();
    checks++; if (bus1.out_valid !== 1'b1) begin errors++; $display("FAIL d1_out_valid got=%b exp=1", bus1.out_valid); end
    checks++; if (bus1.f !== 8'h61) begin errors++; $display("FAIL d1_f0 got=%h exp=61", bus1.f); end
    checks++; if (bus1.in_ready !== 1'b0) begin errors++; $display("FAIL d1_full_ready got=%b exp=0", bus1.in_ready); end
    bus1.out_ready = 1'b1;
    settle();
    checks++; if (bus1.in_ready !== 1'b1) begin errors++; $display("FAIL d1_chain_ready got=%b exp=1", bus1.in_ready); end
    tick();
    bus1.in_valid = 1'b0;
    settle();
    checks++; if (bus1.f !== 8'h62) begin errors++; $display("FAIL d1_f1 got=%h exp=62", bus1.f); end
    checks++; if (bus1.count !== 1'b1) begin errors++; $display("FAIL d1_count got=%0d exp=1", bus1.count); end
    tick();
    checks++; if (bus1.out_valid !== 1'b0) begin errors++; $display("FAIL d1_empty got=%b exp=0", bus1.out_valid); end
    checks++; if (bus1.count !== 1'b0) begin errors++; $display("FAIL d1_count_end got=%0d exp=0", bus1.count); end
  endtask

  initial begin
    rst = 1'b1;
    bus.En = 1'b1;  bus.D = 8'hAA;  bus.in_valid = 1'b1;  bus.out_ready = 1'b0;
    bus1.En = 1'b1; bus1.D = 8'h00; bus1.in_valid = 1'b0; bus1.out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_full_push_pop();
    test_freeze();
    test_mid_reset();
    test_depth1();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
